// File: rtl/mem_pkg.sv
// Shared definitions for the memory access unit: access size encodings,
// FSM state type, default bus timeout and the alignment rule.
package mem_pkg;

  // funct3 encodings for loads (stores use the same low two bits)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Size field is funct3[1:0]
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  // Halfwords need addr[0]=0, words addr[1:0]=00, bytes always aligned.
  // Any size code other than B/H is treated as a word.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    logic ok;
    case (size)
      SZ_B:    ok = 1'b1;
      SZ_H:    ok = ~off[0];
      default: ok = (off == 2'b00);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword/word from a bus read word and
// sign- or zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Shift the addressed byte lane down to bit 0, then extend
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Issues one word-aligned bus access per
// instruction, stalls the pipeline while it is outstanding, aborts after
// TIMEOUT_CYCLES unacknowledged cycles and flags misaligned requests.
//
// Bus handshake: bus_req rises the cycle after a start and, together with
// bus_we/bus_addr/bus_be/bus_wdata, stays stable until the cycle in which
// bus_ack=1 is sampled (transfer completes at that edge) or the timeout
// expires; bus_ack is ignored whenever bus_req is low.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        misalign,
  output logic        bus_err,
  output mem_state_e  dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] load_data_q, load_data_d;
  logic        load_valid_q, load_valid_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic        req_seen;
  logic        start;
  logic        aligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] aligned_rdata;

  load_align u_load_align (
    .rdata  (bus_rdata),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (aligned_rdata)
  );

  // Start decode; rst_n gates it so mem_stall is 0 throughout reset
  always_comb begin
    req_seen = rst_n && (state_q == IDLE) && ex_valid && (ex_mem_rd || ex_mem_wr);
    aligned  = is_aligned(ex_funct3[1:0], ex_addr[1:0]);
    start    = req_seen && aligned;
    case (ex_funct3[1:0])
      SZ_B: begin
        be_calc    = 4'b0001 << ex_addr[1:0];
        wdata_calc = {4{ex_wdata[7:0]}};
      end
      SZ_H: begin
        be_calc    = 4'b0011 << ex_addr[1:0];
        wdata_calc = {2{ex_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = ex_wdata;
      end
    endcase
    mem_stall = start || (state_q == BUSY);
  end

  // Next-state logic for the IDLE/BUSY FSM and all registered outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_be_d     = bus_be_q;
    bus_wdata_d  = bus_wdata_q;
    off_d        = off_q;
    f3_d         = f3_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    misalign_d   = req_seen && !aligned;
    bus_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = BUSY;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = ex_mem_wr;
          bus_addr_d  = {ex_addr[31:2], 2'b00};
          bus_be_d    = be_calc;
          bus_wdata_d = ex_mem_wr ? wdata_calc : 32'd0;
          off_d       = ex_addr[1:0];
          f3_d        = ex_funct3;
        end
      end
      BUSY: begin
        if (bus_ack || (cnt_q == CNT_LAST)) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'd0;
          bus_be_d    = 4'd0;
          bus_wdata_d = 32'd0;
          if (bus_ack) begin
            if (!bus_we_q) begin
              load_valid_d = 1'b1;
              load_data_d  = aligned_rdata;
            end
          end else begin
            bus_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= 32'd0;
      bus_be_q     <= 4'd0;
      bus_wdata_q  <= 32'd0;
      off_q        <= 2'd0;
      f3_q         <= 3'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_be_q     <= bus_be_d;
      bus_wdata_q  <= bus_wdata_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;
  assign load_data  = load_data_q;
  assign load_valid = load_valid_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 4-cycle bus timeout.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign;
  logic        bus_err;
  mem_state_e  dbg_state;

  int checks   = 0;
  int failures = 0;

  // values captured by run_access
  int          stall_cnt;
  int          req_cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic        res_lv;
  logic [31:0] res_ld;
  logic        res_stall;
  logic        res_req;
  logic        res_lv_next;
  int          err_cnt;
  int          lv_cnt;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_mem_rd  (ex_mem_rd),
    .ex_mem_wr  (ex_mem_wr),
    .ex_funct3  (ex_funct3),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .mem_stall  (mem_stall),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .load_data  (load_data),
    .load_valid (load_valid),
    .misalign   (misalign),
    .bus_err    (bus_err),
    .dbg_state  (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid  = 1'b0;
    ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0;
    ex_funct3 = 3'd0;
    ex_addr   = 32'd0;
    ex_wdata  = 32'd0;
  endtask

  // Called at posedge+1 in IDLE. Starts an access, acks it in BUSY cycle
  // ack_cycle, and records stall/request counts and the result.
  task automatic run_access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata,
                            input int ack_cycle);
    ex_valid  = 1'b1;
    ex_mem_rd = ~wr;
    ex_mem_wr = wr;
    ex_funct3 = f3;
    ex_addr   = addr;
    ex_wdata  = wdata;
    stall_cnt = 0;
    req_cnt   = 0;
    #1;
    if (mem_stall) stall_cnt++;
    for (int c = 1; c <= ack_cycle; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        cap_we    = bus_we;
        cap_addr  = bus_addr;
        cap_be    = bus_be;
        cap_wdata = bus_wdata;
      end
      if (c == ack_cycle) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        idle_inputs();
      end
      #1;
      if (mem_stall) stall_cnt++;
      if (bus_req) req_cnt++;
    end
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    #1;
    res_lv    = load_valid;
    res_ld    = load_data;
    res_stall = mem_stall;
    res_req   = bus_req;
    tick();
    res_lv_next = load_valid;
  endtask

  initial begin
    rst_n     = 1'b0;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    idle_inputs();
    tick();
    tick();

    // reset state
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_mem_stall", 32'(mem_stall), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    // LW 0x10, ack in 3rd BUSY cycle
    run_access(1'b0, F3_W, 32'h10, 32'd0, 32'hDEADBEEF, 3);
    chk("lw_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("lw_req_cycles", 32'(req_cnt), 32'd3);
    chk("lw_bus_addr", cap_addr, 32'h10);
    chk("lw_bus_be", 32'(cap_be), 32'hF);
    chk("lw_bus_we", 32'(cap_we), 32'd0);
    chk("lw_load_valid", 32'(res_lv), 32'd1);
    chk("lw_load_data", res_ld, 32'hDEADBEEF);
    chk("lw_stall_after", 32'(res_stall), 32'd0);
    chk("lw_req_after", 32'(res_req), 32'd0);
    chk("lw_lv_one_cycle", 32'(res_lv_next), 32'd0);
    chk("lw_data_held", load_data, 32'hDEADBEEF);

    // LB / LBU at 0x13
    run_access(1'b0, F3_B, 32'h13, 32'd0, 32'h80112233, 1);
    chk("lb_bus_be", 32'(cap_be), 32'b1000);
    chk("lb_bus_addr", cap_addr, 32'h10);
    chk("lb_stall_cycles", 32'(stall_cnt), 32'd2);
    chk("lb_load_valid", 32'(res_lv), 32'd1);
    chk("lb_load_data", res_ld, 32'hFFFFFF80);
    run_access(1'b0, F3_BU, 32'h13, 32'd0, 32'h80112233, 1);
    chk("lbu_load_data", res_ld, 32'h00000080);

    // LH / LHU at 0x02
    run_access(1'b0, F3_H, 32'h2, 32'd0, 32'hF00D1234, 2);
    chk("lh_bus_be", 32'(cap_be), 32'b1100);
    chk("lh_load_data", res_ld, 32'hFFFFF00D);
    run_access(1'b0, F3_HU, 32'h2, 32'd0, 32'hF00D1234, 1);
    chk("lhu_load_data", res_ld, 32'h0000F00D);

    // SH at 0x22
    run_access(1'b1, F3_H, 32'h22, 32'h0000ABCD, 32'h5555AAAA, 2);
    chk("sh_bus_addr", cap_addr, 32'h20);
    chk("sh_bus_be", 32'(cap_be), 32'b1100);
    chk("sh_bus_wdata", cap_wdata, 32'hABCDABCD);
    chk("sh_bus_we", 32'(cap_we), 32'd1);
    chk("sh_no_load_valid", 32'(res_lv), 32'd0);
    chk("sh_load_data_kept", res_ld, 32'h0000F00D);

    // SB at 0x01
    run_access(1'b1, F3_B, 32'h1, 32'h12345678, 32'd0, 1);
    chk("sb_bus_be", 32'(cap_be), 32'b0010);
    chk("sb_bus_wdata", cap_wdata, 32'h78787878);
    chk("sb_bus_addr", cap_addr, 32'h0);

    // misaligned LW at 0x06
    ex_valid  = 1'b1;
    ex_mem_rd = 1'b1;
    ex_funct3 = F3_W;
    ex_addr   = 32'h6;
    #1;
    chk("mis_no_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_no_req", 32'(bus_req), 32'd0);
    idle_inputs();
    #1;
    chk("mis_stall_after", 32'(mem_stall), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(misalign), 32'd0);
    chk("mis_no_req2", 32'(bus_req), 32'd0);

    // no-op: valid without rd/wr; then bus_ack while IDLE
    ex_valid = 1'b1;
    ex_addr  = 32'h100;
    #1;
    chk("noop_stall", 32'(mem_stall), 32'd0);
    tick();
    chk("noop_req", 32'(bus_req), 32'd0);
    idle_inputs();
    bus_ack   = 1'b1;
    bus_rdata = 32'hCAFEF00D;
    tick();
    tick();
    chk("idle_ack_lv", 32'(load_valid), 32'd0);
    chk("idle_ack_state", 32'(dbg_state), 32'(IDLE));
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;

    // timeout: LW 0x40, no ack
    ex_valid  = 1'b1;
    ex_mem_rd = 1'b1;
    ex_funct3 = F3_W;
    ex_addr   = 32'h40;
    tick();
    idle_inputs();
    stall_cnt = 0;
    req_cnt   = 0;
    err_cnt   = 0;
    lv_cnt    = 0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_stall) stall_cnt++;
      if (bus_req) req_cnt++;
      if (bus_err) err_cnt++;
      if (load_valid) lv_cnt++;
      if (c == 5) chk("to_err_at_5", 32'(bus_err), 32'd1);
      tick();
    end
    chk("to_req_cycles", 32'(req_cnt), 32'd4);
    chk("to_stall_cycles", 32'(stall_cnt), 32'd4);
    chk("to_err_pulses", 32'(err_cnt), 32'd1);
    chk("to_no_lv", 32'(lv_cnt), 32'd0);
    chk("to_stall_released", 32'(mem_stall), 32'd0);

    // reset in the 2nd BUSY cycle
    ex_valid  = 1'b1;
    ex_mem_rd = 1'b1;
    ex_funct3 = F3_W;
    ex_addr   = 32'h80;
    tick();
    chk("rb_req_b1", 32'(bus_req), 32'd1);
    tick();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rb_req_dropped", 32'(bus_req), 32'd0);
    chk("rb_stall", 32'(mem_stall), 32'd0);
    chk("rb_addr", bus_addr, 32'd0);
    chk("rb_load_data", load_data, 32'd0);
    chk("rb_state", 32'(dbg_state), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    tick();
    chk("rb_no_err", 32'(bus_err), 32'd0);
    chk("rb_no_lv", 32'(load_valid), 32'd0);
    chk("rb_no_req", 32'(bus_req), 32'd0);
    run_access(1'b0, F3_W, 32'h84, 32'd0, 32'h11223344, 1);
    chk("rb_after_addr", cap_addr, 32'h84);
    chk("rb_after_lv", 32'(res_lv), 32'd1);
    chk("rb_after_ld", res_ld, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent waiting for bus_ack before abort.
REQ-002 The block SHALL have port clk  input  1  single clock, rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port ex_valid  input  1  EX/MEM register holds a valid instruction.
REQ-005 The block SHALL have port ex_mem_rd  input  1  instruction is a load.
REQ-006 The block SHALL have port ex_mem_wr  input  1  instruction is a store.
REQ-007 The block SHALL have port ex_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 The block SHALL have port ex_addr  input  32  byte address from the ALU result.
REQ-009 The block SHALL have port ex_wdata  input  32  store data (rs2).
REQ-010 The block SHALL have port mem_stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM.
REQ-011 The block SHALL have the bus ports bus_req o1, bus_we o1, bus_addr o32 (word-aligned), bus_be o4, bus_wdata o32, bus_ack i1, bus_rdata i32.
REQ-012 The block SHALL have the result ports load_data o32, load_valid o1, misalign o1, bus_err o1.

Function
REQ-013 A start SHALL occur when state is IDLE, ex_valid=1, (ex_mem_rd|ex_mem_wr)=1 and the address is aligned; ex_mem_wr has priority when both are set.
REQ-014 Alignment SHALL be defined as: H/HU/SH require addr[0]=0; W/SW require addr[1:0]=00; byte accesses are always aligned.
REQ-015 The FSM SHALL have states IDLE and BUSY; a start registers the op and moves to BUSY, with bus_req=1 from the next cycle.
REQ-016 mem_stall SHALL be 1 in the start cycle and in every BUSY cycle, including the ack cycle, and 0 otherwise.
REQ-017 In BUSY, bus_req, bus_we, bus_addr, bus_be and bus_wdata SHALL be held stable until bus_ack=1 or timeout.
REQ-018 bus_addr SHALL be {addr[31:2],2'b00}; bus_be SHALL be 0001<<addr[1:0] for B, 0011<<addr[1:0] for H, and 1111 for W; bus_wdata SHALL replicate the byte 4x for B, the halfword 2x for H, and pass through unchanged for W.
REQ-019 On bus_ack in BUSY, the block SHALL drop bus_req and return to IDLE on the next edge; for a load it SHALL register load_data = (bus_rdata >> 8*addr[1:0]), sign- or zero-extended per funct3, and pulse load_valid for exactly one cycle.
REQ-020 A store acknowledged by bus_ack SHALL produce no load_valid pulse.
REQ-021 The wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; when it reaches TIMEOUT_CYCLES, the block SHALL drop bus_req, return to IDLE, pulse bus_err for one cycle and pulse no load_valid.
REQ-022 A misaligned request in IDLE SHALL cause no bus access and no stall, and SHALL produce a registered misalign pulse of one cycle.
REQ-023 ex_valid=0, or both ex_mem_rd and ex_mem_wr at 0, SHALL be a no-op.
REQ-024 Inputs SHALL be ignored while in BUSY, since the upstream stage is frozen by mem_stall.
REQ-025 bus_ack while in IDLE SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state IDLE, counter 0, and all outputs 0, including load_data.
REQ-027 Reset asserted during BUSY SHALL drop bus_req immediately, and the pending access SHALL be abandoned without a pulse on any output.

Structure
REQ-028 Package mem_pkg SHALL hold the funct3 size encodings, the state enum {IDLE,BUSY} and the default TIMEOUT_CYCLES.
REQ-029 The combinational load extraction and extension SHALL be a sub-module named load_align.

Verification
REQ-030 The bench SHALL cover: LW at addr 0x10 with ack after 3 cycles and rdata 0xDEADBEEF -> mem_stall high 4 cycles, then load_data=0xDEADBEEF with load_valid for 1 cycle.
REQ-031 The bench SHALL cover: LB at 0x13 with rdata 0x80112233 -> be=1000, load_data=0xFFFFFF80; LBU at the same address -> load_data=0x00000080.
REQ-032 The bench SHALL cover: SH at 0x22 with wdata 0x0000ABCD -> bus_addr=0x20, be=1100, bus_wdata=0xABCDABCD, bus_we=1, no load_valid.
REQ-033 The bench SHALL cover: LW at 0x06 -> misalign pulses 1 cycle, bus_req stays 0, mem_stall stays 0.
REQ-034 The bench SHALL cover: TIMEOUT_CYCLES=4 with bus_ack never given -> bus_req drops after 4 BUSY cycles, bus_err pulses once, mem_stall releases.
REQ-035 The bench SHALL cover: rst_n dropped in the 2nd BUSY cycle -> bus_req=0 immediately, all outputs 0, and a new access after release completes normally.
